instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  request to instruction memory; accepted in the same cycle it is high.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 SHALL have port imem_rvalid  input  1  read data valid, at least 1 cycle after the accepted request.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect strobe from execute.
REQ-009 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 00.
REQ-010 SHALL have port instr_valid  output  1  instrCode/instr_pc hold a valid instruction for the control unit.
REQ-011 SHALL have port instr_ready  input  1  downstream accepts; transfer occurs when instr_valid and instr_ready are both 1.
REQ-012 SHALL have port instrCode  output  32  fetched instruction word.
REQ-013 SHALL have port instr_pc  output  32  address of instrCode.

Function
REQ-014 SHALL implement FSM states IDLE (no request outstanding, reset state), WAIT (one request outstanding), and DROP (one outstanding response to be discarded).
REQ-015 SHALL allow at most one outstanding memory request.
REQ-016 SHALL assert imem_req in IDLE, or in WAIT in the cycle imem_rvalid=1, only when buffer occupancy after this cycle's push and pop is below DEPTH and redirect_valid=0.
REQ-017 SHALL drive imem_addr = pc and move to or stay in WAIT when imem_req=1; SHALL move to IDLE when WAIT gets rvalid and issues no new request.
REQ-018 SHALL push {pc, imem_rdata} into the buffer and advance pc by 4 on imem_rvalid in WAIT, with 32-bit modulo wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 SHALL, on redirect_valid=1: clear the buffer at the next edge, discarding any same-cycle transfer; load pc with {redirect_pc[31:2],2'b00}; go to DROP if in WAIT without rvalid this cycle, else to IDLE.
REQ-020 SHALL stay in DROP until imem_rvalid, discard that data, and then go to IDLE; a further redirect in DROP only reloads pc.
REQ-021 SHALL drive instr_valid = buffer non-empty, with instrCode/instr_pc showing the oldest entry and held stable while instr_valid=1 and instr_ready=0.
REQ-022 SHALL give a latency of 1 cycle from redirect edge to imem_req (when not in DROP) and 1 cycle from rvalid edge to instr_valid.
REQ-023 SHALL ignore imem_rvalid in IDLE.

Reset
REQ-024 SHALL, while reset=1 (asynchronously), force state=IDLE, pc=RESET_PC, buffer empty, instr_valid=0, and imem_req=0; instrCode and instr_pc are 0.
REQ-025 SHALL issue the first imem_req with imem_addr=RESET_PC in the first cycle after reset deasserts; reset mid-transfer abandons any outstanding response.

Configuration
REQ-026 SHALL, with macro IFETCH_SKID_EN defined, use buffer DEPTH=2, giving a sustained 1 instruction per cycle with 1-cycle memory while instr_ready=1.
REQ-027 SHALL, without IFETCH_SKID_EN, use DEPTH=1, giving at most 1 instruction per 2 cycles; all other behaviour is identical.

Structure
REQ-028 SHALL place the fetch_state_e enum (IDLE, WAIT, DROP) and the INSTR_BYTES=4 constant in shared package cpu_pkg.
REQ-029 SHALL implement the buffer as sub-module instr_buf (DEPTH-entry FIFO of {pc, instr}, with flush, push, and pop), instantiated once.

Verification
REQ-030 SHALL cover reset release with 1-cycle memory: the first three requests are at addresses 0x0, 0x4, 0x8; instr_valid first rises 2 cycles after release with instr_pc=0x0.
REQ-031 SHALL cover instr_ready=0 for 5 cycles with the buffer full: imem_req=0, and instrCode/instr_pc stay stable; on release, instructions arrive in order with no loss or duplication.
REQ-032 SHALL cover redirect_valid with redirect_pc=0x0000_1003 while in WAIT: the response in flight is dropped, the next imem_addr is 0x0000_1000, and no stale instr_pc is presented.
REQ-033 SHALL cover redirect in the same cycle as a valid/ready transfer: the buffer is cleared, and the next presented instr_pc is the redirect target.
REQ-034 SHALL cover pc=0xFFFF_FFFC: the following fetch address is 0x0000_0000.
REQ-035 SHALL cover both configurations: with IFETCH_SKID_EN, 8 instructions take 8 consecutive cycles of instr_valid=1 with instr_ready=1; without it, they take 15 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// Define IFETCH_SKID_EN for a 2-entry fetch buffer; the default build uses 1 entry.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  // The second entry lets a new request go out while the previous word is still unread.
`ifdef IFETCH_SKID_EN
  localparam int IFETCH_DEPTH = 2;
`else
  localparam int IFETCH_DEPTH = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_buf.sv
// Small FIFO of fetched {pc, instr} entries with a synchronous flush.
// The head entry is presented combinationally on dout.
module instr_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  // Flush beats any same-cycle push or pop so nothing stale survives a redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding memory requests feeding a small buffer.
// Buffer depth is 2 when IFETCH_SKID_EN is defined, otherwise 1.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instrCode,
  output logic [31:0] instr_pc
);

  localparam int DEPTH = IFETCH_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   pc_inc;
  logic [CW-1:0] count;
  logic          buf_empty;
  logic          rsp_in_wait;
  logic          push;
  logic          pop;
  int            occ;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign pc_inc      = pc + 32'(INSTR_BYTES);
  assign rsp_in_wait = (state == WAIT) && imem_rvalid;
  assign push        = rsp_in_wait && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign push_entry  = '{pc: pc, instr: imem_rdata};

  assign instr_valid = !buf_empty;
  assign instrCode   = head.instr;
  assign instr_pc    = head.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // pc is the address of the outstanding request while in WAIT, so a back-to-back
  // request issued on the response cycle targets the already-advanced pc.
  always_comb begin
    occ        = int'(count) + (push ? 1 : 0) - (pop ? 1 : 0);
    imem_req   = 1'b0;
    imem_addr  = rsp_in_wait ? pc_inc : pc;
    state_next = state;
    pc_next    = pc;

    if (!reset && !redirect_valid && (occ < DEPTH) &&
        ((state == IDLE) || rsp_in_wait)) begin
      imem_req = 1'b1;
    end

    case (state)
      IDLE: begin
        if (imem_req) state_next = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_next = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          state_next = imem_req ? WAIT : IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (redirect_valid) begin
      pc_next = word_align(redirect_pc);
    end else if (rsp_in_wait) begin
      pc_next = pc_inc;
    end
  end

  instr_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (count),
    .empty (buf_empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a variable-latency memory responder
// and an in-order transfer scoreboard.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_SKID_EN
  localparam int EXP_SPAN = 8;
`else
  localparam int EXP_SPAN = 15;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instrCode;
  logic [31:0] instr_pc;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          mem_lat = 1;
  int          xfer_count = 0;
  logic [31:0] exp_pc = RESET_PC;

  logic        pend;
  int          wait_cnt;
  logic [31:0] paddr;

  instr_fetch #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instrCode      (instrCode),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Memory answers each accepted request after mem_lat cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
      pend        <= 1'b0;
      wait_cnt    <= 0;
      paddr       <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (pend) begin
        if (wait_cnt <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= instr_of(paddr);
          pend        <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end
      if (imem_req) begin
        if (mem_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= instr_of(imem_addr);
        end else begin
          pend     <= 1'b1;
          paddr    <= imem_addr;
          wait_cnt <= mem_lat - 1;
        end
      end
    end
  end

  // Every accepted instruction must be the next sequential one from the last redirect.
  always @(negedge clk) begin
    #3;
    if (reset) begin
      exp_pc = RESET_PC;
    end else if (redirect_valid) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else if (instr_valid && instr_ready) begin
      checkOutput("xfer_pc", instr_pc, exp_pc);
      checkOutput("xfer_code", instrCode, instr_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      xfer_count++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          nreq;
    int          nx;
    int          span;
    int          first_valid;
    int          first_req_cycle;
    int          base;
    int          req_gap;
    logic [31:0] req_addr [3];
    logic [31:0] first_pc;
    logic [31:0] got_addr;
    logic [31:0] prev_addr;
    logic        found;

    repeat (2) @(negedge clk);
    #2;
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_code", instrCode, 32'd0);
    checkOutput("rst_pc", instr_pc, 32'd0);

    // Reset release, first requests and streaming throughput
    @(posedge clk);
    #1 reset = 1'b0;
    nreq = 0; nx = 0; span = 0; first_valid = -1; first_req_cycle = -1;
    first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) req_addr[i] = 32'hFFFF_FFFF;
    for (int c = 0; c < 60 && nx < 8; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (imem_req && nreq < 3) begin
        if (nreq == 0) first_req_cycle = c;
        req_addr[nreq] = imem_addr;
        nreq++;
      end
      if (instr_valid && first_valid < 0) begin
        first_valid = c;
        first_pc    = instr_pc;
      end
      if (first_valid >= 0) span++;
      if (instr_valid) nx++;
    end
    checkOutput("first_req_cycle", 32'(first_req_cycle), 32'd0);
    checkOutput("req0_addr", req_addr[0], 32'h0);
    checkOutput("req1_addr", req_addr[1], 32'h4);
    checkOutput("req2_addr", req_addr[2], 32'h8);
    checkOutput("first_valid_cycle", 32'(first_valid), 32'd2);
    checkOutput("first_valid_pc", first_pc, 32'h0);
    checkOutput("stream_count", 32'(nx), 32'd8);
    checkOutput("stream_span", 32'(span), 32'(EXP_SPAN));

    // Back-pressure with a full buffer
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("stall_req", 32'(imem_req), 32'd0);
      checkOutput("stall_valid", 32'(instr_valid), 32'd1);
      checkOutput("stall_pc", instr_pc, exp_pc);
      checkOutput("stall_code", instrCode, instr_of(exp_pc));
    end
    base = xfer_count;
    repeat (20) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("release_xfers", 32'((xfer_count - base) >= 8), 32'd1);

    // Redirect while a slow response is in flight
    mem_lat = 3;
    do_reset();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("slow_req", 32'(imem_req), 32'd1);
    checkOutput("slow_addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_1003);
    checkOutput("redir_req_blocked", 32'(imem_req), 32'd0);
    found = 1'b0; got_addr = '0; req_gap = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (imem_req) begin
        found    = 1'b1;
        got_addr = imem_addr;
        req_gap  = i;
        break;
      end
    end
    mem_lat = 1;
    checkOutput("redir_req_seen", 32'(found), 32'd1);
    checkOutput("redir_addr", got_addr, 32'h0000_1000);
    checkOutput("drop_wait_cycles", 32'(req_gap), 32'd2);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("redir_valid_seen", 32'(found), 32'd1);
    checkOutput("redir_first_pc", instr_pc, 32'h0000_1000);

    // Redirect coinciding with a valid/ready transfer
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (instr_valid) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        found          = 1'b1;
        break;
      end
    end
    checkOutput("xfer_redir_hit", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("flush_empty", 32'(instr_valid), 32'd0);
    checkOutput("flush_req", 32'(imem_req), 32'd1);
    checkOutput("flush_addr", imem_addr, 32'h0000_2000);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("flush_valid_seen", 32'(found), 32'd1);
    checkOutput("flush_first_pc", instr_pc, 32'h0000_2000);
    checkOutput("flush_first_code", instrCode, instr_of(32'h0000_2000));

    // Address wrap at the top of the address space
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF6);
    found = 1'b0; prev_addr = '0; got_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (imem_req) begin
        if (prev_addr == 32'hFFFF_FFFC) begin
          got_addr = imem_addr;
          found    = 1'b1;
          break;
        end
        prev_addr = imem_addr;
      end
    end
    checkOutput("wrap_seen", 32'(found), 32'd1);
    checkOutput("wrap_addr", got_addr, 32'h0000_0000);
    base = xfer_count;
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_xfers", 32'((xfer_count - base) >= 4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
